// File: rtl/cache_line_fill_unit.sv
// cache_line_fill_unit: per-L1 miss engine (optional dirty-victim writeback, then 8-beat line read).
// Define FILL_EARLY_RESTART_EN to add crit_valid/crit_word early-restart outputs.
//
// state   | meaning
// IDLE    | wait for miss_req; stray response beats are acked and dropped
// WB_REQ  | write request held with beat 0 until arb_reqack
// WB_DATA | stream victim beats 1..LINE_BEATS-1, one per cycle
// RD_REQ  | read request held until arb_reqack
// RD_RESP | collect response beats into fill_line; gaps allowed
// DONE    | miss_done pulse, then back to IDLE
module cache_line_fill_unit #(
    parameter int   WIDTH      = 64,
    parameter int   TAG_WIDTH  = 13,
    parameter int   LINE_BEATS = 8,
    parameter logic SRC_ID     = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        miss_req,
    input  logic [63:0]                 miss_addr,
    input  logic                        victim_dirty,
    input  logic [63:0]                 victim_addr,
    input  logic [WIDTH*LINE_BEATS-1:0] victim_data,
    output logic                        miss_done,
    output logic [WIDTH*LINE_BEATS-1:0] fill_line,
`ifdef FILL_EARLY_RESTART_EN
    output logic                        crit_valid,
    output logic [WIDTH-1:0]            crit_word,
`endif
    output logic                        arb_req,
    output logic [63:0]                 arb_addr,
    output logic [TAG_WIDTH-1:0]        arb_tag,
    input  logic                        arb_reqack,
    output logic [WIDTH-1:0]            arb_reqdata,
    input  logic                        arb_respcyc,
    input  logic [WIDTH-1:0]            arb_resp,
    output logic                        arb_respack
);

    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
    localparam logic [63:0] LINE_MASK = ~64'h3f;
    localparam logic [TAG_WIDTH-1:0] RD_TAG = TAG_WIDTH'({1'b1, 4'b0001, 7'b0, SRC_ID});
    localparam logic [TAG_WIDTH-1:0] WR_TAG = TAG_WIDTH'({1'b0, 4'b0001, 7'b0, SRC_ID});

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_DATA,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t                       state;
    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             cnt_inc;
    logic [63:0]                  miss_line_q;
    logic [WIDTH*LINE_BEATS-1:0]  victim_q;
`ifdef FILL_EARLY_RESTART_EN
    logic [CNT_W-1:0]             crit_idx_q;
`endif

    assign cnt_inc = cnt + 1'b1;

    // Every beat offered is consumed in every state; nothing can back-pressure the arbiter.
    assign arb_respack = arb_respcyc & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            miss_line_q <= '0;
            victim_q    <= '0;
            miss_done   <= 1'b0;
            fill_line   <= '0;
            arb_req     <= 1'b0;
            arb_addr    <= '0;
            arb_tag     <= '0;
            arb_reqdata <= '0;
`ifdef FILL_EARLY_RESTART_EN
            crit_idx_q  <= '0;
            crit_valid  <= 1'b0;
            crit_word   <= '0;
`endif
        end else begin
            miss_done <= 1'b0;
`ifdef FILL_EARLY_RESTART_EN
            crit_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        miss_line_q <= miss_addr & LINE_MASK;
                        victim_q    <= victim_data;
                        arb_req     <= 1'b1;
                        cnt         <= '0;
`ifdef FILL_EARLY_RESTART_EN
                        crit_idx_q  <= miss_addr[3 +: CNT_W];
`endif
                        if (victim_dirty) begin
                            arb_addr    <= victim_addr & LINE_MASK;
                            arb_tag     <= WR_TAG;
                            arb_reqdata <= victim_data[WIDTH-1:0];
                            state       <= WB_REQ;
                        end else begin
                            arb_addr <= miss_addr & LINE_MASK;
                            arb_tag  <= RD_TAG;
                            state    <= RD_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    if (arb_reqack) begin
                        cnt         <= CNT_W'(1);
                        arb_reqdata <= victim_q[WIDTH +: WIDTH];
                        state       <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    if (cnt == LAST_BEAT) begin
                        cnt      <= '0;
                        arb_addr <= miss_line_q;
                        arb_tag  <= RD_TAG;
                        state    <= RD_REQ;
                    end else begin
                        cnt         <= cnt_inc;
                        arb_reqdata <= victim_q[cnt_inc*WIDTH +: WIDTH];
                    end
                end
                RD_REQ: begin
                    if (arb_reqack) begin
                        arb_req <= 1'b0;
                        cnt     <= '0;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (arb_respcyc) begin
                        fill_line[cnt*WIDTH +: WIDTH] <= arb_resp;
                        cnt <= cnt_inc;
`ifdef FILL_EARLY_RESTART_EN
                        if (cnt == crit_idx_q) begin
                            crit_valid <= 1'b1;
                            crit_word  <= arb_resp;
                        end
`endif
                        if (cnt == LAST_BEAT) begin
                            miss_done <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
